approx_mul_pipe: RTL

- Parametrised, pipelined unsigned multiplier with a per-transaction mode: exact, or approximate, where the low columns use a carry-free OR compression.
- Successor to the fixed 8x8 combinational approximate multipliers. Adds a width parameter, a selectable number of approximate columns, a fixed 3-stage pipeline with valid/ready backpressure, an error output and a transfer counter.
- Sits between an operand source and the accelerator datapath or an error-characterisation harness.

---
 rtl/approx_mul_pkg.sv | 15 +
 rtl/pp_col_compress.sv | 34 +++
 rtl/approx_mul_pipe.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/approx_mul_pkg.sv
// rtl/approx_mul_pkg.sv - shared mode encoding, pipeline depth and column-mask helper for approx_mul_pipe
// Contents: MODE_EXACT / MODE_APPROX tag values, PIPE_LAT stage count,
//           col_mask(k, approx_cols) = 1 when product column k is OR-compressed.
package approx_mul_pkg;

    localparam logic MODE_EXACT  = 1'b0;
    localparam logic MODE_APPROX = 1'b1;

    localparam int PIPE_LAT = 3;

    function automatic logic col_mask(input int k, input int approx_cols);
        return (k < approx_cols);
    endfunction

endpackage

// File: rtl/pp_col_compress.sv
// rtl/pp_col_compress.sv - partial-product column compressor: OR of low columns, arithmetic sum of high columns
// Ports:
//   a, b      in   WIDTH     unsigned operands
//   low_or    out  2*WIDTH   bit k = OR of column k for k < APPROX_COLS, else 0
//   high_sum  out  2*WIDTH   arithmetic sum of all pp bits in columns k >= APPROX_COLS
module pp_col_compress
    import approx_mul_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 7
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] low_or,
    output logic [2*WIDTH-1:0] high_sum
);

    localparam int PW = 2 * WIDTH;

    always_comb begin
        low_or   = '0;
        high_sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                if (col_mask(i + j, APPROX_COLS)) begin
                    low_or[i+j] = low_or[i+j] | (a[j] & b[i]);
                end else if (a[j] & b[i]) begin
                    high_sum = high_sum + (PW'(1) << (i + j));
                end
            end
        end
    end

endmodule

// File: rtl/approx_mul_pipe.sv
// rtl/approx_mul_pipe.sv - 3-stage valid/ready pipelined multiplier with exact or low-column OR-approximate mode
// Ports:
//   CLK, RST              clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready     operand handshake; in_a, in_b operands, in_mode 0 exact / 1 approximate
//   out_valid/out_ready   result handshake; out_p product, out_err exact minus approximate, out_mode tag
//   stat_cnt              saturating count of completed output transfers
module approx_mul_pipe
    import approx_mul_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 7,
    parameter int CNT_W       = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic [2*WIDTH-1:0]   out_err,
    output logic                 out_mode,
    output logic [CNT_W-1:0]     stat_cnt
);

    localparam int PW = 2 * WIDTH;

    logic adv1, adv2, adv3;

    logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [WIDTH-1:0] a1_q, a1_d, b1_q, b1_d;
    logic             m1_q, m1_d, m2_q, m2_d, m3_q, m3_d;
    logic [PW-1:0]    or2_q, or2_d, hi2_q, hi2_d, ex2_q, ex2_d;
    logic [PW-1:0]    p3_q, p3_d, err3_q, err3_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [PW-1:0]    low_or_c, high_sum_c, approx_c;

    pp_col_compress #(
        .WIDTH       (WIDTH),
        .APPROX_COLS (APPROX_COLS)
    ) u_compress (
        .a        (a1_q),
        .b        (b1_q),
        .low_or   (low_or_c),
        .high_sum (high_sum_c)
    );

    // low_or only has bits below APPROX_COLS and high_sum is a multiple of
    // 2^APPROX_COLS, so OR-ing them is the same as adding them.
    assign approx_c = or2_q | hi2_q;

    // Bubble-collapsing advance: a stage may load whenever it is empty or
    // the stage below it is moving.
    always_comb begin
        adv3 = !v3_q || out_ready;
        adv2 = !v2_q || adv3;
        adv1 = !v1_q || adv2;
    end

    always_comb begin
        v1_d   = v1_q;
        a1_d   = a1_q;
        b1_d   = b1_q;
        m1_d   = m1_q;
        v2_d   = v2_q;
        or2_d  = or2_q;
        hi2_d  = hi2_q;
        ex2_d  = ex2_q;
        m2_d   = m2_q;
        v3_d   = v3_q;
        p3_d   = p3_q;
        err3_d = err3_q;
        m3_d   = m3_q;
        cnt_d  = cnt_q;

        if (adv1) begin
            v1_d = in_valid;
            a1_d = in_a;
            b1_d = in_b;
            m1_d = in_mode;
        end

        if (adv2) begin
            v2_d  = v1_q;
            or2_d = low_or_c;
            hi2_d = high_sum_c;
            ex2_d = PW'(a1_q) * PW'(b1_q);
            m2_d  = m1_q;
        end

        if (adv3) begin
            v3_d = v2_q;
            m3_d = m2_q;
            if (m2_q == MODE_EXACT) begin
                p3_d   = ex2_q;
                err3_d = '0;
            end else begin
                p3_d   = approx_c;
                err3_d = ex2_q - approx_c;
            end
        end

        if (v3_q && out_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v1_q   <= 1'b0;
            a1_q   <= '0;
            b1_q   <= '0;
            m1_q   <= 1'b0;
            v2_q   <= 1'b0;
            or2_q  <= '0;
            hi2_q  <= '0;
            ex2_q  <= '0;
            m2_q   <= 1'b0;
            v3_q   <= 1'b0;
            p3_q   <= '0;
            err3_q <= '0;
            m3_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            v1_q   <= v1_d;
            a1_q   <= a1_d;
            b1_q   <= b1_d;
            m1_q   <= m1_d;
            v2_q   <= v2_d;
            or2_q  <= or2_d;
            hi2_q  <= hi2_d;
            ex2_q  <= ex2_d;
            m2_q   <= m2_d;
            v3_q   <= v3_d;
            p3_q   <= p3_d;
            err3_q <= err3_d;
            m3_q   <= m3_d;
            cnt_q  <= cnt_d;
        end
    end

    assign in_ready  = adv1;
    assign out_valid = v3_q;
    assign out_p     = p3_q;
    assign out_err   = err3_q;
    assign out_mode  = m3_q;
    assign stat_cnt  = cnt_q;

endmodule
